action_selector: RTL and testbench
==================================

ACTION_SELECTOR -- requirements
Module: action_selector

Interface
REQ-001 SHALL have parameter: Q_WIDTH, 16, signed Q-value width.
REQ-002 SHALL have parameter: N_ACTIONS, 16, number of actions; fixed so the action index is 4 bits.
REQ-003 SHALL have parameter: EPS_WIDTH, 8, epsilon threshold width.
REQ-004 SHALL have one clock and an asynchronous active-low reset, ports in this order: clk  in  1  clock, rising-edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: start  in  1  request one action selection; accepted only in IDLE.
REQ-006 SHALL have port: epsilon  in  EPS_WIDTH  exploration threshold, sampled on start accept.
REQ-007 SHALL have port: q_addr  out  4  Q-table read address for the current state row.
REQ-008 SHALL have port: q_data  in  Q_WIDTH  signed Q-value, valid one cycle after q_addr.
REQ-009 SHALL have port: busy  out  1  high from the cycle after accept until at_valid, inclusive.
REQ-010 SHALL have port: at  out  4  selected action index, feeds the downstream one-hot enable decoder.
REQ-011 SHALL have port: at_valid  out  1  one-cycle pulse; at is stable from this cycle until the next at_valid.
REQ-012 SHALL have port: explored  out  1  high with at_valid when at came from exploration.

Function
REQ-013 SHALL implement FSM IDLE -> SCAN -> DONE -> IDLE.
REQ-014 SHALL accept start at cycle T: in IDLE with start=1, move to SCAN; start SHALL be ignored in SCAN and DONE.
REQ-015 SHALL drive q_addr=k during cycle T+1+k, k=0..15, and hold q_addr=0 outside SCAN.
REQ-016 SHALL compare q_data at T+2+k as signed; running max replaced only on strictly greater; ties keep the lowest index.
REQ-017 SHALL initialise the running max from index 0's data, not from a constant, so all-negative rows work.
REQ-018 SHALL enter DONE at T+18, assert at_valid for exactly that cycle, then return to IDLE; fixed latency is 18 cycles accept-to-valid.
REQ-019 SHALL allow start at T+19 at the earliest, giving back-to-back throughput of one selection per 19 cycles.
REQ-020 SHALL update at only in the DONE cycle; at holds its value otherwise.
REQ-021 SHALL keep explored=0 and at equal to the greedy argmax when the feature of REQ-026 is absent.

Reset
REQ-022 SHALL, on rst_n low at any time, force state IDLE, at=0, at_valid=0, explored=0, busy=0, q_addr=0, running max/index cleared.
REQ-023 SHALL drop any selection in flight when reset arrives mid-SCAN; no at_valid pulse follows reset release.
REQ-024 SHALL load the LFSR seed 16'hACE1 on reset.
REQ-025 SHALL return to IDLE after reset release and accept start on the first clock edge after release.

Configuration
REQ-026 SHALL compile epsilon-greedy exploration only when macro ACTION_SELECTOR_EXPLORE_EN is defined.
REQ-027 SHALL, with the macro defined, run a 16-bit Fibonacci LFSR every cycle (taps 16,14,13,11).
REQ-028 SHALL, with the macro defined, sample lfsr[7:0] < epsilon at accept, together with lfsr[11:8].
REQ-029 SHALL, when that comparison is true, output the sampled lfsr[11:8] as at with explored=1; the scan still runs so latency stays 18.
REQ-030 SHALL, without the macro, contain no LFSR, ignore epsilon, and tie explored to 0.
REQ-031 SHALL keep latency identical in both builds.

Structure
REQ-032 SHALL place Q_WIDTH, N_ACTIONS, the FSM state enum and the LFSR seed in shared package rl_pkg.
REQ-033 SHALL use one sub-module, rl_lfsr16: enable, seed on reset, 16-bit state out.
REQ-034 SHALL instantiate rl_lfsr16 only under ACTION_SELECTOR_EXPLORE_EN.

Verification
REQ-035 SHALL cover: Q row with Q[9]=100, others 0 -> at=9, at_valid at T+18, explored=0.
REQ-036 SHALL cover: all Q=-5 -> at=0 (tie, lowest index); row with Q[3]=Q[12]=700, max -> at=3.
REQ-037 SHALL cover: Q[0]=-32768, Q[15]=-32767, others -32768 -> at=15 (signed compare).
REQ-038 SHALL cover: reset asserted at T+8 -> no at_valid, at=0, busy=0; next start completes normally.
REQ-039 SHALL cover: start held high continuously -> at_valid at T+18, T+37, T+56; start pulses during busy ignored.
REQ-040 SHALL cover, with the macro, epsilon=255 for 256 selections -> explored=1 except when lfsr[7:0]=255, at equals sampled lfsr[11:8]; epsilon=0 -> explored always 0.

Source files
------------

// File: rtl/rl_pkg.sv
// rtl/rl_pkg.sv - shared types and constants for the action selector slice
package rl_pkg;

    localparam int Q_WIDTH   = 16;
    localparam int N_ACTIONS = 16;
    localparam int ACT_W     = 4;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/action_selector_if.sv
// rtl/action_selector_if.sv - request, Q-table read and result signals of the action selector
interface action_selector_if #(
    parameter int Q_WIDTH   = 16,
    parameter int EPS_WIDTH = 8
);
    import rl_pkg::*;

    logic                        start;
    logic [EPS_WIDTH-1:0]        epsilon;
    logic [ACT_W-1:0]            q_addr;
    logic signed [Q_WIDTH-1:0]   q_data;
    logic                        busy;
    logic [ACT_W-1:0]            at;
    logic                        at_valid;
    logic                        explored;

    modport master (
        output start, epsilon, q_data,
        input  q_addr, busy, at, at_valid, explored
    );

    modport slave (
        input  start, epsilon, q_data,
        output q_addr, busy, at, at_valid, explored
    );

endinterface

// File: rtl/rl_lfsr16.sv
// rtl/rl_lfsr16.sv - 16-bit Fibonacci LFSR, loads SEED on reset
module rl_lfsr16 #(
    parameter logic [15:0] SEED = rl_pkg::LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [15:0] state
);
    import rl_pkg::*;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (enable) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/action_selector.sv
// rtl/action_selector.sv - greedy argmax over a 16-entry Q row; epsilon exploration under ACTION_SELECTOR_EXPLORE_EN
module action_selector #(
    parameter int Q_WIDTH   = rl_pkg::Q_WIDTH,
    parameter int N_ACTIONS = rl_pkg::N_ACTIONS,
    parameter int EPS_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    action_selector_if.slave bus
);
    import rl_pkg::*;

    state_t                     state;
    logic [4:0]                 cnt;
    logic [ACT_W-1:0]           q_addr_r;
    logic signed [Q_WIDTH-1:0]  max_q;
    logic [ACT_W-1:0]           max_idx;
    logic signed [Q_WIDTH-1:0]  nxt_max;
    logic [ACT_W-1:0]           nxt_idx;
    logic signed [Q_WIDTH-1:0]  q_s;
    logic [ACT_W-1:0]           at_r;
    logic                       at_valid_r;
    logic                       explored_r;
    logic                       busy_r;
    logic                       hit;
    logic [ACT_W-1:0]           hit_act;
    logic                       accept;

    assign q_s    = bus.q_data;
    assign accept = (state == IDLE) && bus.start;

    // cnt=1 carries index 0: seed the running max from data, never from a constant
    always_comb begin
        nxt_max = max_q;
        nxt_idx = max_idx;
        if (cnt == 5'd1) begin
            nxt_max = q_s;
            nxt_idx = '0;
        end else if (q_s > max_q) begin
            nxt_max = q_s;
            nxt_idx = ACT_W'(cnt - 5'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            q_addr_r   <= '0;
            max_q      <= '0;
            max_idx    <= '0;
            at_r       <= '0;
            at_valid_r <= 1'b0;
            explored_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            at_valid_r <= 1'b0;
            explored_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= SCAN;
                        busy_r   <= 1'b1;
                        cnt      <= '0;
                        q_addr_r <= '0;
                    end
                end
                SCAN: begin
                    cnt      <= cnt + 5'd1;
                    q_addr_r <= (cnt < 5'(N_ACTIONS - 1)) ? ACT_W'(cnt + 5'd1) : '0;
                    if (cnt != 5'd0) begin
                        max_q   <= nxt_max;
                        max_idx <= nxt_idx;
                    end
                    if (cnt == 5'(N_ACTIONS)) begin
                        state      <= DONE;
                        at_valid_r <= 1'b1;
                        at_r       <= hit ? hit_act : nxt_idx;
                        explored_r <= hit;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ACTION_SELECTOR_EXPLORE_EN
    logic [15:0] lfsr;

    rl_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (1'b1),
        .state  (lfsr)
    );

    // exploration decision and random action are frozen at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit     <= 1'b0;
            hit_act <= '0;
        end else if (accept) begin
            hit     <= EPS_WIDTH'(lfsr[7:0]) < bus.epsilon;
            hit_act <= lfsr[11:8];
        end
    end
`else
    logic [EPS_WIDTH-1:0] unused_eps;
    logic                 unused_accept;

    assign unused_eps    = bus.epsilon;
    assign unused_accept = accept;
    assign hit           = 1'b0;
    assign hit_act       = '0;
`endif

    assign bus.q_addr   = q_addr_r;
    assign bus.at       = at_r;
    assign bus.at_valid = at_valid_r;
    assign bus.explored = explored_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_action_selector.sv
// tb/tb_action_selector.sv - self-checking bench for action_selector
module tb_action_selector;
    import rl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    action_selector_if #(.Q_WIDTH(16), .EPS_WIDTH(8)) bus ();

    action_selector #(.Q_WIDTH(16), .N_ACTIONS(16), .EPS_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int errors = 0;

    logic [15:0] qrow [16];
    logic [15:0] qd;
    always @(posedge clk) qd <= qrow[bus.q_addr];
    assign bus.q_data = qd;

    logic [15:0] model_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_lfsr <= 16'hACE1;
        else        model_lfsr <= {model_lfsr[14:0], model_lfsr[15] ^ model_lfsr[13] ^ model_lfsr[12] ^ model_lfsr[10]};
    end

    typedef struct {
        logic [15:0][15:0] q;
        logic [3:0]        exp_at;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] argmax();
        logic [3:0] best = 4'd0;
        for (int i = 1; i < 16; i++)
            if ($signed(qrow[i]) > $signed(qrow[best])) best = 4'(i);
        return best;
    endfunction

    task automatic run_sel(input logic [7:0] eps, output int lat, output logic [3:0] a,
                           output logic e, output logic [15:0] lf);
        logic addr_ok = 1'b1;
        logic busy_ok = 1'b1;
        logic [3:0] exp_addr;
        @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b1;
        bus.epsilon = eps;
        lf = model_lfsr;
        lat = 0;
        a = 4'd0;
        e = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            exp_addr = (n <= 16) ? 4'(n - 1) : 4'd0;
            if (bus.q_addr !== exp_addr) addr_ok = 1'b0;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (bus.at_valid) begin
                lat = n;
                a = bus.at;
                e = bus.explored;
                break;
            end
        end
        check("latency", lat, 18);
        check("q_addr_seq", addr_ok, 1);
        check("busy_during", busy_ok, 1);
        @(negedge clk);
        check("valid_pulse_busy_end", {bus.at_valid, bus.busy}, 0);
        check("at_hold", bus.at, a);
    endtask

    int lat;
    logic [3:0] a;
    logic e;
    logic [15:0] lf;
    logic [7:0] eps;
    int hits [$];
    logic seen;

    initial begin
        bus.start = 1'b0;
        bus.epsilon = 8'd0;
        for (int i = 0; i < 16; i++) qrow[i] = 16'd0;

        for (int v = 0; v < 6; v++) vecs[v].q = '0;
        vecs[0].q[9] = 16'd100;                         vecs[0].exp_at = 4'd9;
        for (int i = 0; i < 16; i++) vecs[1].q[i] = -16'sd5;
        vecs[1].exp_at = 4'd0;
        vecs[2].q[3] = 16'd700; vecs[2].q[12] = 16'd700; vecs[2].exp_at = 4'd3;
        for (int i = 0; i < 16; i++) vecs[3].q[i] = 16'h8000;
        vecs[3].q[15] = 16'h8001;                       vecs[3].exp_at = 4'd15;
        for (int i = 0; i < 16; i++) vecs[4].q[i] = 16'(i * 10);
        vecs[4].q[0] = 16'h7FFF; vecs[4].q[15] = 16'h7FFF; vecs[4].exp_at = 4'd0;
        for (int i = 0; i < 16; i++) vecs[5].q[i] = -16'sd2;
        vecs[5].q[7] = -16'sd1;                         vecs[5].exp_at = 4'd7;

        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.at, bus.at_valid, bus.explored, bus.busy, bus.q_addr}, 0);

        // reset release and start on the same negedge: first edge accepts
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 16; i++) qrow[i] = vecs[v].q[i];
            run_sel(8'd0, lat, a, e, lf);
            check($sformatf("vec%0d_at", v), a, vecs[v].exp_at);
            check($sformatf("vec%0d_explored", v), e, 0);
        end

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 16; i++)
                qrow[i] = (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 3)) - 16'd2;
`ifdef ACTION_SELECTOR_EXPLORE_EN
            eps = 8'd0;
`else
            eps = 8'($urandom);
`endif
            run_sel(eps, lat, a, e, lf);
            check("rand_at", a, argmax());
            check("rand_explored", e, 0);
        end

        // reset at T+8 aborts the selection
        for (int i = 0; i < 16; i++) qrow[i] = vecs[0].q[i];
        @(negedge clk);
        bus.start = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {bus.at, bus.at_valid, bus.explored, bus.busy, bus.q_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (bus.at_valid) seen = 1'b1;
        end
        check("no_valid_after_reset", seen, 0);
        check("at_after_reset", bus.at, 0);
        run_sel(8'd0, lat, a, e, lf);
        check("post_reset_at", a, 4'd9);

        // start held high: one selection per 19 cycles
        for (int i = 0; i < 16; i++) qrow[i] = vecs[2].q[i];
        @(negedge clk);
        bus.start = 1'b1;
        bus.epsilon = 8'd0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (bus.at_valid) begin
                hits.push_back(n);
                check("held_at", bus.at, 4'd3);
            end
        end
        bus.start = 1'b0;
        check("held_count", hits.size(), 3);
        if (hits.size() == 3) begin
            check("held_t0", hits[0], 18);
            check("held_t1", hits[1], 37);
            check("held_t2", hits[2], 56);
        end
        repeat (25) @(negedge clk);

`ifdef ACTION_SELECTOR_EXPLORE_EN
        for (int r = 0; r < 256; r++) begin
            for (int i = 0; i < 16; i++) qrow[i] = 16'($urandom);
            run_sel(8'd255, lat, a, e, lf);
            check("eps255_explored", e, (lf[7:0] < 8'd255) ? 1 : 0);
            check("eps255_at", a, (lf[7:0] < 8'd255) ? {28'd0, lf[11:8]} : {28'd0, argmax()});
        end
        for (int r = 0; r < 32; r++) begin
            for (int i = 0; i < 16; i++) qrow[i] = 16'($urandom);
            run_sel(8'd0, lat, a, e, lf);
            check("eps0_explored", e, 0);
            check("eps0_at", a, argmax());
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
